// File: rtl/am2922_dmux.sv
// am2922_dmux: 1-to-8 addressable output latch with registered select/polarity,
// auto-increment serial loading and tri-state outputs. Optional AM2922_DMUX_DECODE_EN adds dec_.
module am2922_dmux (
    input  logic       clk,
    input  logic       clr,
    input  logic       d,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       pol,
    input  logic       re_,
    input  logic       we_,
    input  logic       inc_,
    input  logic       oe_,
`ifdef AM2922_DMUX_DECODE_EN
    input  logic       dec_,
`endif
    output logic [7:0] y,
    output logic       last
);

    localparam int unsigned N_OUT = 8;
    localparam int unsigned SEL_W = 3;

    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             r_polr;
    logic             w_polr_nxt;
    logic [N_OUT-1:0] r_lat;
    logic [N_OUT-1:0] w_lat_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             w_dec_n;

`ifdef AM2922_DMUX_DECODE_EN
    assign w_dec_n = dec_;
`else
    assign w_dec_n = 1'b1;
`endif

    // Next-state: decode beats write; a select load always wins over increment.
    always_comb begin
        w_sel_nxt  = r_sel;
        w_polr_nxt = r_polr;
        w_lat_nxt  = r_lat;
        w_last_nxt = r_last;

        if (!w_dec_n) begin
            w_lat_nxt  = N_OUT'(1) << r_sel;
            w_last_nxt = 1'b0;
        end else if (!we_) begin
            w_lat_nxt[r_sel] = d;
            w_last_nxt       = !inc_ && (r_sel == SEL_W'(N_OUT - 1));
            if (!inc_ && re_) begin
                w_sel_nxt = r_sel + SEL_W'(1);
            end
        end else if (!re_) begin
            w_last_nxt = 1'b0;
        end

        if (!re_) begin
            w_sel_nxt  = {c, b, a};
            w_polr_nxt = pol;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sel  <= '0;
            r_polr <= 1'b0;
            r_lat  <= '0;
            r_last <= 1'b0;
        end else begin
            r_sel  <= w_sel_nxt;
            r_polr <= w_polr_nxt;
            r_lat  <= w_lat_nxt;
            r_last <= w_last_nxt;
        end
    end

    assign y    = oe_ ? {N_OUT{1'bz}} : (r_lat ^ {N_OUT{r_polr}});
    assign last = r_last;

endmodule

// File: tb/tb_am2922_dmux.sv
// Directed scoreboard bench for am2922_dmux; decode checks run when AM2922_DMUX_DECODE_EN is defined.
module tb_am2922_dmux;

    logic       clk = 1'b0;
    logic       clr;
    logic       d;
    logic       a;
    logic       b;
    logic       c;
    logic       pol;
    logic       re_;
    logic       we_;
    logic       inc_;
    logic       oe_;
    logic       dec_;
    wire  [7:0] y;
    wire        last;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] y;
        logic       last;
    } exp_t;

    exp_t sb[$];

    am2922_dmux dut (
        .clk  (clk),
        .clr  (clr),
        .d    (d),
        .a    (a),
        .b    (b),
        .c    (c),
        .pol  (pol),
        .re_  (re_),
        .we_  (we_),
        .inc_ (inc_),
        .oe_  (oe_),
`ifdef AM2922_DMUX_DECODE_EN
        .dec_ (dec_),
`endif
        .y    (y),
        .last (last)
    );

    // Weak pull-ups make a released bus read back as all ones.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (y[gi]);
    end

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic re, input logic we, input logic inc,
                       input logic [2:0] cba, input logic p, input logic dd);
        re_       = re;
        we_       = we;
        inc_      = inc;
        {c, b, a} = cba;
        pol       = p;
        d         = dd;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] ey, input logic el);
        exp_t e;
        e.tag  = tag;
        e.y    = ey;
        e.last = el;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=nonzero");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (y === e.y) else begin
                failures++;
                $error("FAIL %s y observed=%b expected=%b", e.tag, y, e.y);
            end
            checks++;
            assert (last === e.last) else begin
                failures++;
                $error("FAIL %s last observed=%b expected=%b", e.tag, last, e.last);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq;
        logic [7:0] acc;

        clr  = 1'b1;
        oe_  = 1'b0;
        dec_ = 1'b1;
        ctl(1, 1, 1, 3'b000, 0, 0);
        expect_out("reset", 8'h00, 1'b0);
        tick();
        tick();
        check_out();
        clr = 1'b0;

        // Single addressed write and clear.
        ctl(0, 1, 1, 3'b101, 0, 0);
        expect_out("load_sel5", 8'h00, 1'b0);
        tick(); check_out();
        ctl(1, 0, 1, 3'b000, 0, 1);
        expect_out("write_bit5", 8'h20, 1'b0);
        tick(); check_out();
        d = 1'b0;
        expect_out("clear_bit5", 8'h00, 1'b0);
        tick(); check_out();

        // Serial fill of all eight bits.
        ctl(0, 1, 1, 3'b000, 0, 0);
        expect_out("load_sel0", 8'h00, 1'b0);
        tick(); check_out();
        seq = 8'b01001101;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ctl(1, 0, 0, 3'b000, 0, seq[i]);
            acc[i] = seq[i];
            expect_out($sformatf("serial_%0d", i), acc, (i == 7));
            tick(); check_out();
        end

        // Polarity load clears last and inverts the outputs.
        ctl(0, 1, 1, 3'b000, 1, 0);
        expect_out("pol_invert", 8'hB2, 1'b0);
        tick(); check_out();
        ctl(0, 1, 1, 3'b000, 0, 0);
        expect_out("pol_restore", 8'h4D, 1'b0);
        tick(); check_out();

        // Select wrapped to 0; idle edges with inc_=0 must not advance it.
        ctl(1, 0, 1, 3'b000, 0, 0);
        expect_out("wrap_bit0_clear", 8'h4C, 1'b0);
        tick(); check_out();
        ctl(1, 1, 0, 3'b000, 0, 0);
        expect_out("idle_hold", 8'h4C, 1'b0);
        tick(); check_out();
        ctl(1, 0, 1, 3'b000, 0, 1);
        expect_out("idle_no_inc", 8'h4D, 1'b0);
        tick(); check_out();

        ctl(0, 1, 1, 3'b111, 0, 0);
        expect_out("load_sel7", 8'h4D, 1'b0);
        tick(); check_out();
        ctl(1, 0, 0, 3'b000, 0, 1);
        expect_out("last_set", 8'hCD, 1'b1);
        tick(); check_out();

        // Asynchronous clear between edges, then a write attempted under clear.
        ctl(1, 0, 1, 3'b000, 0, 1);
        #2 clr = 1'b1;
        #1;
        expect_out("async_clr", 8'h00, 1'b0);
        check_out();
        oe_ = 1'b1;
        #1;
        expect_out("clr_hiz", 8'hFF, 1'b0);
        check_out();
        oe_ = 1'b0;
        expect_out("clr_blocks_write", 8'h00, 1'b0);
        tick(); check_out();
        clr = 1'b0;

        // oe_ only gates the pins; state still updates.
        oe_ = 1'b1;
        ctl(1, 0, 1, 3'b000, 0, 1);
        expect_out("write_hiz", 8'hFF, 1'b0);
        tick(); check_out();
        ctl(1, 1, 1, 3'b000, 0, 0);
        oe_ = 1'b0;
        #1;
        expect_out("hiz_write_kept", 8'h01, 1'b0);
        check_out();

        // Same-edge load and write: write uses old sel, no increment.
        ctl(0, 1, 1, 3'b010, 0, 0);
        expect_out("load_sel2", 8'h01, 1'b0);
        tick(); check_out();
        ctl(0, 0, 0, 3'b110, 0, 1);
        expect_out("conflict_old_sel", 8'h05, 1'b0);
        tick(); check_out();
        ctl(1, 0, 1, 3'b000, 0, 1);
        expect_out("conflict_new_sel6", 8'h45, 1'b0);
        tick(); check_out();

`ifdef AM2922_DMUX_DECODE_EN
        ctl(0, 1, 1, 3'b011, 0, 0);
        expect_out("load_sel3", 8'h45, 1'b0);
        tick(); check_out();
        ctl(1, 0, 0, 3'b000, 0, 0);
        dec_ = 1'b0;
        expect_out("decode_sel3", 8'h08, 1'b0);
        tick(); check_out();
        dec_ = 1'b1;
        ctl(0, 1, 1, 3'b111, 0, 0);
        expect_out("dec_load_sel7", 8'h08, 1'b0);
        tick(); check_out();
        ctl(1, 0, 0, 3'b000, 0, 1);
        expect_out("dec_last_set", 8'h88, 1'b1);
        tick(); check_out();
        ctl(1, 0, 0, 3'b000, 0, 0);
        dec_ = 1'b0;
        expect_out("decode_clears_last", 8'h01, 1'b0);
        tick(); check_out();
        dec_ = 1'b1;
        ctl(1, 0, 1, 3'b000, 0, 0);
        expect_out("decode_no_inc", 8'h00, 1'b0);
        tick(); check_out();
`endif

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/am2922_dmux.md
Name: am2922_dmux

Overview:
- Companion to am2922 on the write side: a 1-to-8 demultiplexer / addressable output latch in the Am29xx bitslice model collection.
- A registered 3-bit select (c,b,a) and polarity register steer a single data bit into one of eight output latch bits.
- An auto-increment mode turns the block into a serial-to-parallel loader: eight consecutive writes fill y[0]..y[7].
- Outputs are polarity-controlled and tri-statable, mirroring the am2922 pin conventions.

Parameters:
- none (fixed 8-way device, like the rest of the Am29xx models)

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-high reset
- d  input  1  serial data bit to be written
- a  input  1  select bit 0
- b  input  1  select bit 1
- c  input  1  select bit 2 (MSB)
- pol  input  1  polarity value, loaded with the select
- re_  input  1  active-low register enable; loads {c,b,a} and pol
- we_  input  1  active-low write enable; writes d into the latch bit at the current select
- inc_  input  1  active-low auto-increment; advances select after each write
- oe_  input  1  active-low output enable
- y  output  8  latch outputs XOR {8{pol register}}; high-Z when oe_=1
- last  output  1  registered flag: the previous write landed on address 7 with inc_=0

Behaviour:
- State: sel[2:0], polr, lat[7:0], last.
- Reset: clr=1 asynchronously forces sel=0, polr=0, lat=8'h00 and last=0. While clr=1, y=8'h00 if oe_=0. Reset mid-write wins; no write occurs on that edge.
- Output path is combinational: y = oe_ ? 8'hZZ : (lat ^ {8{polr}}). oe_ does not affect internal state.
- All state updates happen on the rising clk edge with clr=0.
- Write: if we_=0, lat[sel] <= d. The write uses sel as it stood before the edge; other bits hold.
- Select load: if re_=0, sel <= {c,b,a} and polr <= pol. A newly loaded select takes effect for writes on the next edge.
- Increment: if inc_=0 and we_=0 and re_=1, sel <= sel+1 modulo 8 (7 wraps to 0).
- Priority: a select load (re_=0) overrides increment. A write on the same edge still uses the old sel.
- last: on each edge with we_=0, last <= (inc_=0 && sel==7). On an edge with re_=0 and we_=1, last <= 0. Otherwise last holds.
- Idle edge (re_=1, we_=1): all state holds, regardless of inc_.
- X or Z on an active control input propagates X into the affected state. This is model behaviour only and is not relied upon.

Optional Feature:
- Macro: AM2922_DMUX_DECODE_EN.
- Defined: adds input port dec_ (1 bit, active low). On an edge with dec_=0, lat <= one-hot(sel) using the pre-edge sel. This is the Am2921-style registered 1-of-8 decoder function.
  - dec_=0 takes priority over we_; neither the write nor the increment occurs on that edge.
  - last <= 0 on that edge.
  - re_ still loads the select and polarity normally.
- Undefined: the dec_ port is absent and the block behaves exactly as if dec_=1.

Test Plan:
- Pulse clr=1 with oe_=0 -> y=8'h00 and last=0 immediately, without a clock. Then set oe_=1 -> y=8'hZZ.
- re_=0, {c,b,a}=3'b101, pol=0 on one edge, then we_=0, d=1, inc_=1 on the next -> y=8'b00100000. Write d=0 on a further edge -> y=8'h00.
- Load sel=0 and pol=0, then eight edges with we_=0, inc_=0, d=1,0,1,1,0,0,1,0 -> y=8'b01001101. last=1 after the 8th edge, and sel has wrapped to 0.
- With lat=8'b01001101, load pol=1 with re_=0, we_=1 -> y=8'b10110010 and last=0. Load pol=0 again -> y=8'b01001101.
- Same-edge conflict: sel=2, then re_=0, {c,b,a}=3'b110, we_=0, d=1, inc_=0 -> bit 2 is set, not bit 6. sel=6 on the next cycle (no increment).
- AM2922_DMUX_DECODE_EN defined: load sel=3, then dec_=0 with we_=0, d=0 -> y=8'b00001000 and last=0.
